// File: rtl/packet_parser_crc8_if.sv
// Read-burst channel and payload byte stream of the packet parser.
// master = parser side, slave = memory/sink side.
interface packet_parser_crc8_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic              rvalid;
    logic              rlast;
    logic              rready;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;

    modport master (
        output araddr, arlen, arvalid, rready, out_data, out_valid, out_last,
        input  arready, rdata, rvalid, rlast, out_ready
    );

    modport slave (
        input  araddr, arlen, arvalid, rready, out_data, out_valid, out_last,
        output arready, rdata, rvalid, rlast, out_ready
    );
endinterface

// File: rtl/packet_parser_crc8.sv
// Packet parser: fetches a packet from memory with at most two read bursts
// (header word, then remaining body words), streams the payload bytes out
// with backpressure and checks them against the stored CRC8 (poly 0x07).
module packet_parser_crc8 #(
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  crc_err,
    output logic                  len_err,
    output logic [3:0]            pkt_type,
    packet_parser_crc8_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_HDR_AR, S_HDR_R, S_EMIT, S_BODY_AR, S_BODY_R, S_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_araddr;
    logic [3:0]        r_arlen;
    logic              r_arvalid;
    logic              r_rready;
    logic [3:0]        r_cnt;
    logic [3:0]        r_pkt_type;
    logic [7:0]        r_stored_crc;
    logic [7:0]        r_crc;
    logic [31:0]       r_buf;
    logic [2:0]        r_word;
    logic [4:0]        r_idx;
    logic              r_body_req;
    logic [7:0]        r_out_data;
    logic              r_out_valid;
    logic              r_out_last;
    logic              r_busy;
    logic              r_done;
    logic              r_crc_err;
    logic              r_len_err;

    // One MSB-first CRC8 step over a whole byte.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int b = 0; b < 8; b++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    logic [2:0] w_words;          // total words in the packet (1..5)
    logic [4:0] w_next_idx;       // payload index after the current byte
    logic [4:0] w_next_pos;       // packet byte position of that next byte
    logic [4:0] w_cur_pos;        // packet byte position of the current byte
    logic [7:0] w_crc_next;
    logic       w_body_last_beat;

    assign w_words          = 3'(({1'b0, r_cnt} + 5'd6) >> 2);
    assign w_next_idx       = r_idx + 5'd1;
    assign w_next_pos       = w_next_idx + 5'd2;
    assign w_cur_pos        = r_idx + 5'd2;
    assign w_crc_next       = crc8_byte(r_crc, r_out_data);
    assign w_body_last_beat = ((r_word + 3'd1) == (w_words - 3'd1));

    assign bus.araddr    = r_araddr;
    assign bus.arlen     = r_arlen;
    assign bus.arvalid   = r_arvalid;
    assign bus.rready    = r_rready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign busy          = r_busy;
    assign done          = r_done;
    assign crc_err       = r_crc_err;
    assign len_err       = r_len_err;
    assign pkt_type      = r_pkt_type;

    // Control FSM; every output is registered and changes only on state transitions
    // or handshakes, so address/data stay stable while waiting on the other side.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_cnt        <= '0;
            r_pkt_type   <= '0;
            r_stored_crc <= '0;
            r_crc        <= '0;
            r_buf        <= '0;
            r_word       <= '0;
            r_idx        <= '0;
            r_body_req   <= 1'b0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_crc_err    <= 1'b0;
            r_len_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base    <= {base_addr[ADDR_W-1:2], 2'b00};
                        r_araddr  <= {base_addr[ADDR_W-1:2], 2'b00};
                        r_arlen   <= 4'd0;
                        r_arvalid <= 1'b1;
                        r_busy    <= 1'b1;
                        r_crc_err <= 1'b0;
                        r_len_err <= 1'b0;
                        r_crc     <= 8'h00;
                        r_state   <= S_HDR_AR;
                    end
                end
                S_HDR_AR: begin
                    if (bus.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_HDR_R;
                    end
                end
                S_HDR_R: begin
                    if (bus.rvalid) begin
                        // Header word: byte 0 header, byte 1 CRC, lanes 2/3 first payload.
                        r_rready     <= 1'b0;
                        r_cnt        <= bus.rdata[3:0];
                        r_pkt_type   <= bus.rdata[7:4];
                        r_stored_crc <= bus.rdata[15:8];
                        r_buf        <= bus.rdata;
                        r_word       <= 3'd0;
                        r_idx        <= 5'd0;
                        r_body_req   <= 1'b0;
                        r_len_err    <= r_len_err | ~bus.rlast;
                        r_out_valid  <= 1'b1;
                        r_out_data   <= bus.rdata[23:16];
                        r_out_last   <= (bus.rdata[3:0] == 4'd0);
                        r_state      <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (r_out_valid && bus.out_ready) begin
                        r_crc <= w_crc_next;
                        r_idx <= w_next_idx;
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_crc_err   <= (w_crc_next != r_stored_crc);
                            r_state     <= S_DONE;
                        end else if (w_next_pos[4:2] == r_word) begin
                            r_out_data <= r_buf[{w_next_pos[1:0], 3'b000} +: 8];
                            r_out_last <= (w_next_idx == {1'b0, r_cnt});
                        end else begin
                            // Buffered word exhausted: fetch the next body word.
                            r_out_valid <= 1'b0;
                            if (r_body_req) begin
                                r_rready <= 1'b1;
                                r_state  <= S_BODY_R;
                            end else begin
                                r_araddr  <= r_base + ADDR_W'(4);
                                r_arlen   <= {1'b0, w_words} - 4'd2;
                                r_arvalid <= 1'b1;
                                r_state   <= S_BODY_AR;
                            end
                        end
                    end
                end
                S_BODY_AR: begin
                    if (bus.arready) begin
                        r_arvalid  <= 1'b0;
                        r_body_req <= 1'b1;
                        r_rready   <= 1'b1;
                        r_state    <= S_BODY_R;
                    end
                end
                S_BODY_R: begin
                    if (bus.rvalid) begin
                        r_rready    <= 1'b0;
                        r_buf       <= bus.rdata;
                        r_word      <= r_word + 3'd1;
                        r_len_err   <= r_len_err | (bus.rlast != w_body_last_beat);
                        r_out_valid <= 1'b1;
                        r_out_data  <= bus.rdata[{w_cur_pos[1:0], 3'b000} +: 8];
                        r_out_last  <= (r_idx == {1'b0, r_cnt});
                        r_state     <= S_EMIT;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
